// File: rtl/as_pack.sv
// as_pack: shared fetch-path widths, NOP constant and queue entry layout.
package as_pack;
  localparam int iaddr_width = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0]            instr;
    logic [iaddr_width-1:0] pc;
    logic [iaddr_width-1:0] pc_4;
  } fetch_entry_t;
endpackage

// File: rtl/as_fetch_queue.sv
// as_fetch_queue: fetch-to-decode instruction queue with flush and registered-only output.
module as_fetch_queue
  import as_pack::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [iaddr_width-1:0]     pc_i,
  input  logic [iaddr_width-1:0]     pc_4_i,
  input  logic [31:0]                instr_i,
  output logic                       ready_o,
  input  logic                       flush_i,
  output logic                       valid_o,
  output logic [31:0]                instr_o,
  output logic [iaddr_width-1:0]     pc_o,
  output logic [iaddr_width-1:0]     pc_4_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic push, pop;
  fetch_entry_t head_e;
  assign ready_o = count < DEPTH[AW:0];
  assign valid_o = count != '0;
  assign push = valid_i && ready_o && !flush_i;
  assign pop = valid_o && ready_i && !flush_i;
  assign count_o = count;
  assign head_e = mem[head];
  // empty queue presents a NOP so decode never sees stale storage
  assign instr_o = valid_o ? head_e.instr : NOP_INSTR;
  assign pc_o = valid_o ? head_e.pc : '0;
  assign pc_4_o = valid_o ? head_e.pc_4 : '0;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(pop);
      tail <= tail + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) mem[tail] <= '{instr: instr_i, pc: pc_i, pc_4: pc_4_i};
endmodule

// File: tb/tb_as_fetch_queue.sv
// tb_as_fetch_queue: directed checks of reset, fill/drain, streaming, flush, wrap and async reset.
module tb_as_fetch_queue;
  import as_pack::*;
  localparam logic [31:0] MASK = 32'hA5A5_0000;
  logic clk_i = 0, rst_i = 0, valid_i = 0, flush_i = 0, ready_i = 0;
  logic [iaddr_width-1:0] pc_i = '0, pc_4_i = '0, pc_o, pc_4_o;
  logic [31:0] instr_i = '0, instr_o;
  logic ready_o, valid_o;
  logic [2:0] count_o;
  int errors = 0, checks = 0;

  as_fetch_queue #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i), .pc_4_i(pc_4_i),
    .instr_i(instr_i), .ready_o(ready_o), .flush_i(flush_i), .valid_o(valid_o),
    .instr_o(instr_o), .pc_o(pc_o), .pc_4_o(pc_4_o), .ready_i(ready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    valid_i = v;
    pc_i = pc;
    pc_4_i = pc + 4;
    instr_i = pc ^ MASK;
  endtask

  initial begin
    logic [31:0] q[$];
    logic v, r, pu, po;
    int n;
    // reset held while inputs toggle
    for (int i = 0; i < 3; i++) begin
      offer(i[0] == 0, 32'h40);
      ready_i = 1;
      step;
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_ready", 32'(ready_o), 1);
      chk("rst_count", 32'(count_o), 0);
      chk("rst_instr", instr_o, 32'h13);
    end
    chk("rst_pc", pc_o, 0);
    chk("rst_pc4", pc_4_o, 0);
    rst_i = 1;
    ready_i = 0;
    // fill with ready_i low
    for (int i = 0; i < 4; i++) begin
      offer(1, 32'(4 * i));
      if (i == 0) chk("no_bypass", 32'(valid_o), 0);
      step;
      chk("fill_count", 32'(count_o), 32'(i + 1));
      chk("fill_head", pc_o, 0);
    end
    chk("full_ready", 32'(ready_o), 0);
    offer(1, 32'h10);
    step;
    chk("fifth_ignored", 32'(count_o), 4);
    offer(0, 0);
    ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", pc_o, 32'(4 * i));
      chk("drain_pc4", pc_4_o, 32'(4 * i + 4));
      chk("drain_instr", instr_o, 32'(4 * i) ^ MASK);
      step;
      chk("drain_ready", 32'(ready_o), 1);
      chk("drain_count", 32'(count_o), 32'(3 - i));
    end
    chk("drain_valid", 32'(valid_o), 0);
    chk("drain_nop", instr_o, 32'h13);
    // steady stream
    for (int k = 0; k < 20; k++) begin
      offer(1, 32'h100 + 32'(4 * k));
      step;
      chk("stream_count", 32'(count_o), 1);
      chk("stream_pc", pc_o, 32'h100 + 32'(4 * k));
    end
    offer(0, 0);
    step;
    chk("stream_end", 32'(valid_o), 0);
    // flush over three queued entries
    ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      offer(1, 32'h180 + 32'(4 * i));
      step;
    end
    chk("flush_pre", 32'(count_o), 3);
    offer(1, 32'h200);
    flush_i = 1;
    step;
    flush_i = 0;
    offer(0, 0);
    chk("flush_count", 32'(count_o), 0);
    chk("flush_valid", 32'(valid_o), 0);
    chk("flush_ready", 32'(ready_o), 1);
    offer(1, 32'h300);
    step;
    offer(0, 0);
    chk("post_flush_pc", pc_o, 32'h300);
    chk("post_flush_count", 32'(count_o), 1);
    ready_i = 1;
    step;
    chk("post_flush_empty", 32'(valid_o), 0);
    // interleaved push/pop across pointer wrap, against a queue model
    n = 0;
    for (int k = 0; k < 30; k++) begin
      v = (k % 3) != 2;
      r = k >= 4 && (k % 5) != 1;
      offer(v, 32'h400 + 32'(4 * n));
      ready_i = r;
      chk("wrap_valid", 32'(valid_o), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("wrap_pc", pc_o, q[0]);
        chk("wrap_instr", instr_o, q[0] ^ MASK);
      end
      pu = v && q.size() < 4;
      po = r && q.size() > 0;
      step;
      if (po) void'(q.pop_front());
      if (pu) begin
        q.push_back(32'h400 + 32'(4 * n));
        n++;
      end
      chk("wrap_count", 32'(count_o), 32'(q.size()));
    end
    // mid-operation asynchronous reset
    offer(0, 0);
    flush_i = 1;
    step;
    flush_i = 0;
    ready_i = 0;
    offer(1, 32'h500);
    step;
    offer(1, 32'h504);
    step;
    offer(0, 0);
    chk("mid_pre_count", 32'(count_o), 2);
    #2 rst_i = 0;
    #1;
    chk("async_valid", 32'(valid_o), 0);
    chk("async_count", 32'(count_o), 0);
    chk("async_ready", 32'(ready_o), 1);
    chk("async_instr", instr_o, 32'h13);
    #1 rst_i = 1;
    offer(1, 32'h600);
    step;
    offer(0, 0);
    chk("after_rst_pc", pc_o, 32'h600);
    chk("after_rst_count", 32'(count_o), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/as_fetch_queue.md
AS_FETCH_QUEUE -- requirements
Module: as_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, at least 2.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 valid_i  input  1  fetch stage offers an instruction this cycle.
REQ-005 pc_i  input  iaddr_width  PC of the offered instruction.
REQ-006 pc_4_i  input  iaddr_width  PC+4 of the offered instruction (return address).
REQ-007 instr_i  input  32  instruction word read from I-Mem at pc_i.
REQ-008 ready_o  input-side  output  1  queue accepts a push; also drives the fetch stage stall_n input.
REQ-009 flush_i  input  1  taken branch or jalr redirect (pc_src); discards all queued instructions.
REQ-010 valid_o  output  1  head entry is valid for decode.
REQ-011 instr_o  output  32  head instruction.
REQ-012 pc_o  output  iaddr_width  head PC.
REQ-013 pc_4_o  output  iaddr_width  head PC+4.
REQ-014 ready_i  input  1  decode consumes the head this cycle (decode not stalled).
REQ-015 count_o  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Push occurs when valid_i && ready_o && !flush_i; the entry SHALL be written at the tail.
REQ-017 Pop occurs when valid_o && ready_i && !flush_i; the head pointer SHALL advance.
REQ-018 ready_o SHALL equal (count < DEPTH); it SHALL NOT depend on ready_i.
REQ-019 valid_o SHALL equal (count != 0).
REQ-020 Latency: a pushed entry SHALL appear at the outputs on the cycle after the push, with no same-cycle bypass.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-022 Full (count == DEPTH): ready_o = 0 and valid_i is ignored; a pop in that cycle SHALL make ready_o = 1 on the next cycle.
REQ-023 Empty: valid_o = 0, instr_o = 32'h0000_0013 (NOP), pc_o = 0, pc_4_o = 0; ready_i is ignored.
REQ-024 Flush takes priority over push and pop: on the next cycle count = 0, the pointers are equal, and the entry offered in the flush cycle is discarded.
REQ-025 Pointers are $clog2(DEPTH) bits and SHALL wrap modulo DEPTH without a gap; full and empty SHALL be distinguished by count, never by pointer equality alone.
REQ-026 count SHALL never exceed DEPTH or underflow below 0 under any input combination.
REQ-027 Stored data SHALL NOT be reset; only control state (pointers, count) is reset.

Reset
REQ-028 While rst_i = 0: pointers = 0, count = 0, valid_o = 0, ready_o = 1, count_o = 0, instr_o = NOP, pc_o = 0, pc_4_o = 0, taking effect asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately; the first push after release is accepted on the first rising edge with rst_i = 1.

Structure
REQ-030 iaddr_width, the NOP constant (NOP_INSTR) and the packed entry typedef fetch_entry_t {instr, pc, pc_4} SHALL live in as_pack.
REQ-031 Storage SHALL be a register array of fetch_entry_t within as_fetch_queue; no sub-module is required.
REQ-032 The top level SHALL connect ready_o to the fetch stage stall_n_i and flush_i to the same signal that drives its pc_src_i.

Verification
REQ-033 Reset: hold rst_i = 0, toggle valid_i -> valid_o = 0, ready_o = 1, count_o = 0, instr_o = 0x00000013.
REQ-034 Fill/drain: push PCs 0x0, 0x4, 0x8, 0xC with ready_i = 0 -> count_o = 4, ready_o = 0; a fifth push is ignored; then ready_i = 1 -> pc_o sequence 0x0, 0x4, 0x8, 0xC, pc_4_o = pc_o + 4, then valid_o = 0.
REQ-035 Steady stream: valid_i = ready_i = 1 for 20 cycles from PC 0x100 -> count_o stays 1 after the first cycle, and pc_o increments by 4 each cycle with 1-cycle latency.
REQ-036 Flush: queue holds 3 entries, assert flush_i together with valid_i (PC 0x200) -> next cycle count_o = 0, valid_o = 0; a push of 0x300 then appears as the head.
REQ-037 Wrap-around: DEPTH = 4, perform 10 interleaved push/pop patterns that cross the pointer wrap -> output order matches a scoreboard, and count_o matches the reference model every cycle.
REQ-038 Mid-operation reset: with 2 entries queued, pulse rst_i low between clock edges -> valid_o falls without waiting for a clock edge; after release, the first output is the first entry pushed after reset.
